simple_rw_fifo: RTL

Synchronous show-ahead FIFO built on the team's simple_rw_ram. It sits directly upstream of the RAM: it generates a_addr, b_addr, b_we and b_wrdata, and consumes a_rddata.
- Exposes valid/ready write and read streams.
- Holds the RAM read address on the head entry, so a_rddata drives r_data directly with no extra output register.
- Used as the standard buffering stage between pipelined producers and consumers.

---
 rtl/simple_rw_ram.sv | 41 ++++
 rtl/simple_rw_fifo.sv | 117 +++++++++++
 2 files changed

// File: rtl/simple_rw_ram.sv
// simple_rw_ram: one synchronous read port (a) and one write port (b).
// A read that hits the address being written in the same cycle returns
// the old contents; the FIFO in front of this RAM relies on that.
module simple_rw_ram #(
  parameter int    ADDR_WIDTH      = 4,
  parameter int    DATA_WIDTH      = 64,
  parameter string DEFAULT_CONTENT = ""
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  output logic [DATA_WIDTH-1:0] a_rddata,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic                  b_we,
  input  logic [DATA_WIDTH-1:0] b_wrdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rddata;

  // DEFAULT_CONTENT is kept so the RAM can be dropped in wherever the
  // preloadable variant is used; this implementation has no preload path.
  logic w_unused_content;
  assign w_unused_content = (DEFAULT_CONTENT == "");

  // Write port b.
  always_ff @(posedge clk) begin
    if (b_we) begin
      r_mem[b_addr] <= b_wrdata;
    end
  end

  // Read port a: registered read, old data on a same-address write.
  always_ff @(posedge clk) begin
    r_rddata <= r_mem[a_addr];
  end

  assign a_rddata = r_rddata;

endmodule

// File: rtl/simple_rw_fifo.sv
// simple_rw_fifo: show-ahead FIFO in front of simple_rw_ram.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The producer holds w_data while w_valid is high and w_ready
// is low; the FIFO holds r_data while r_valid is high and r_ready is low.
// ready never depends combinationally on valid on either side.
//
// The RAM read address is kept on the head entry (or the next entry when a
// pop is happening), so the RAM output is the head and needs no extra
// output register.
module simple_rw_fifo #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int                DEPTH      = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = DEPTH[ADDR_WIDTH:0];

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_valid_q;

  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_rd_ptr_next;
  logic [ADDR_WIDTH-1:0] w_a_addr;
  logic [DATA_WIDTH-1:0] w_a_rddata;
  logic [ADDR_WIDTH:0]   w_count_after_pop;

  // Handshakes; nothing is accepted during the reset cycle.
  assign w_ready = (r_count != FULL_COUNT);
  assign w_push  = rstn && w_valid && w_ready;
  assign w_pop   = rstn && r_valid_q && r_ready;

  assign w_rd_ptr_next = r_rd_ptr + ADDR_WIDTH'(1);

  // On a pop the RAM must already fetch the next entry so it is presented
  // right after the edge; otherwise keep re-reading the head.
  assign w_a_addr = w_pop ? w_rd_ptr_next : r_rd_ptr;

  // Entries written before this edge that survive it. The same-cycle push is
  // left out: its RAM location cannot be read back until the next cycle.
  assign w_count_after_pop = r_count - {{ADDR_WIDTH{1'b0}}, w_pop};

  // Write pointer advances on every accepted push, wrapping naturally.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
    end
  end

  // Read pointer advances on every pop, wrapping naturally.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= w_rd_ptr_next;
    end
  end

  // Occupancy: +1 per push, -1 per pop, unchanged when both happen.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_after_pop + {{ADDR_WIDTH{1'b0}}, w_push};
    end
  end

  // Head is visible once an entry older than this cycle remains stored.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_valid_q <= 1'b0;
    end else begin
      r_valid_q <= (w_count_after_pop != '0);
    end
  end

  simple_rw_ram #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .DATA_WIDTH      (DATA_WIDTH),
    .DEFAULT_CONTENT ("")
  ) u_ram (
    .clk      (clk),
    .a_addr   (w_a_addr),
    .a_rddata (w_a_rddata),
    .b_addr   (r_wr_ptr),
    .b_we     (w_push),
    .b_wrdata (w_data)
  );

  assign r_valid = r_valid_q;
  assign r_data  = w_a_rddata;
  assign count   = r_count;

  // Structural invariants, checked out of reset.
  a_count_range : assert property (@(posedge clk) disable iff (!rstn)
    r_count <= FULL_COUNT);
  a_ptr_diff : assert property (@(posedge clk) disable iff (!rstn)
    (r_wr_ptr - r_rd_ptr) == r_count[ADDR_WIDTH-1:0]);
  a_valid_nonempty : assert property (@(posedge clk) disable iff (!rstn)
    r_valid_q |-> (r_count != '0));

endmodule
